frv_masked_bitwise: RTL and testbench
=====================================

// Module: frv_masked_bitwise
// PURPOSE
//  Multi-cycle boolean-masked bitwise unit in the execute stage. Computes
//  mask.b.{xor,and,ior,not} on 2-share operands; writes both result shares to
//  the wide writeback (rd = share0, rd_hi = share1), which the RVFI masked-insn
//  checkers consume. Output is re-randomised with fresh PRNG bits; the unmasked
//  value (s0^s1) is the required architectural result.
// PARAMETERS
//  XLEN      32  operand/share width in bits
//  GLITCH_REG 1  1: register ISW cross terms before recombination (+1 cycle)
// PORTS
//  g_clk      in   1     core clock
//  g_resetn   in   1     asynchronous active-low reset
//  flush      in   1     abort in-flight op; unit returns to IDLE
//  valid      in   1     request valid; held stable until ready
//  op_xor     in   1     one-hot op select (exactly one high when valid)
//  op_and     in   1     "
//  op_ior     in   1     "
//  op_not     in   1     "
//  rs1_s0     in   XLEN  operand A share 0
//  rs1_s1     in   XLEN  operand A share 1
//  rs2_s0     in   XLEN  operand B share 0 (ignored for op_not)
//  rs2_s1     in   XLEN  operand B share 1 (ignored for op_not)
//  prng       in   XLEN  fresh random word, valid every cycle
//  prng_upd   out  1     pulse: prng word consumed, source must advance
//  ready      out  1     one-cycle pulse: rd_s0/rd_s1 valid this cycle
//  rd_s0      out  XLEN  result share 0
//  rd_s1      out  XLEN  result share 1
// BEHAVIOUR
//  - Reset: state=IDLE; ready=0, prng_upd=0, rd_s0=rd_s1=0, all share regs 0.
//  - FSM IDLE -> (valid & ~ready & (op_and|op_ior)) -> CROSS
//          [-> GLITCH_REG ? RECOMB] -> DONE -> IDLE. XOR/NOT: IDLE -> DONE.
//  - DONE: ready=1 for exactly one cycle, outputs registered; next cycle IDLE.
//    valid still high in that cycle (held by pipeline) must NOT restart; new op
//    accepted only from IDLE after a cycle with ready=0.
//  - Latency valid->ready: XOR/NOT 1 cycle; AND/IOR 2 (GLITCH_REG=0) or 3.
//  - m = prng latched at accept; prng_upd pulses in accept cycle only.
//  - XOR: s0=a0^b0^m, s1=a1^b1^m.  NOT: s0=~a0^m, s1=a1^m.
//  - AND (ISW, r=m): s0=(a0&b0)^r; s1=(a1&b1)^((r^(a0&b1))^(a1&b0)); the
//    bracketed term r^(a0&b1) is registered in CROSS before adding a1&b0.
//  - IOR: a|b = ~(~a&~b); invert share0 of A and B, run AND, invert s0 of result.
//  - Shares never combined unmasked in any single combinational cone; a0/a1
//    never share a register.
//  - flush (any state): next state IDLE, ready=0, no prng_upd; share regs
//    cleared to 0. flush with valid in IDLE: request dropped.
//  - flush and DONE same cycle: ready suppressed (flush wins).
//  - Reset asserted mid-op: immediate return to reset values; no ready.
//  - All arithmetic bitwise, XLEN wide; no carries, no width extension.
// TESTING
//  - XOR: a=(0xDEADBEEF^0x1234,0x1234), b=(0x0F0F0F0F^0x55,0x55), prng=0xA5A5A5A5
//    -> ready at +1, rd_s0^rd_s1=0xD1A2B1E0, rd_s0=0xD1A2B1E0^0x1261^0xA5A5A5A5.
//  - AND: a unmasked 0xFFFF0000, b 0x0FF00FF0, random shares -> ready at +2/+3,
//    s0^s1=0x0FF00000; repeat 1000 random vectors, check vs a&b.
//  - IOR: a=0x00000001, b=0x80000000 -> s0^s1=0x80000001; NOT a=0 -> 0xFFFFFFFF.
//  - Handshake: valid held 4 cycles on XOR -> exactly one ready pulse, one
//    prng_upd pulse; back-to-back ops each produce one ready.
//  - flush in CROSS cycle of AND -> no ready, state IDLE next cycle, next XOR ok.
//  - g_resetn low mid-AND -> ready=0, rd_s0=rd_s1=0 immediately, IDLE on release.

Source files
------------

// File: rtl/frv_masked_bitwise.sv
// frv_masked_bitwise
//   Multi-cycle boolean-masked bitwise unit (execute stage). Evaluates
//   xor/and/ior/not on 2-share operands and returns both result shares,
//   re-randomised with a fresh PRNG word. The unmasked result is rd_s0^rd_s1.
// Ports
//   g_clk, g_resetn        clock, asynchronous active-low reset
//   flush                  abort any in-flight op, return to IDLE
//   valid, op_*            request and one-hot op select (held until ready)
//   rs1_s0/s1, rs2_s0/s1   operand shares (rs2 ignored for op_not)
//   prng                   fresh random word, valid every cycle
//   prng_upd               pulse in the accept cycle: prng word consumed
//   ready                  one-cycle pulse: rd_s0/rd_s1 valid
//   rd_s0, rd_s1           result shares (registered)
module frv_masked_bitwise #(
  parameter int unsigned XLEN       = 32,
  parameter bit          GLITCH_REG = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            valid,
  input  logic            op_xor,
  input  logic            op_and,
  input  logic            op_ior,
  input  logic            op_not,
  input  logic [XLEN-1:0] rs1_s0,
  input  logic [XLEN-1:0] rs1_s1,
  input  logic [XLEN-1:0] rs2_s0,
  input  logic [XLEN-1:0] rs2_s1,
  input  logic [XLEN-1:0] prng,
  output logic            prng_upd,
  output logic            ready,
  output logic [XLEN-1:0] rd_s0,
  output logic [XLEN-1:0] rd_s1
);

  typedef enum logic [1:0] {IDLE, CROSS, RECOMB, DONE} state_t;

  state_t state, state_nxt;

  logic            ready_q;  // ready seen last cycle: blocks restart on held valid
  logic            accept;
  logic            ior_q;
  logic [XLEN-1:0] a0_q, a1_q, b0_q, b1_q, m_q;
  logic [XLEN-1:0] t_q;      // r ^ (a0 & b1)
  logic [XLEN-1:0] u_q;      // t ^ (a1 & b0), registered when GLITCH_REG
  logic [XLEN-1:0] in_a0, in_b0;
  logic [XLEN-1:0] and_s0, and_s1, recomb;
  logic            write_and;

  // IOR runs as AND on inverted operands: invert share 0 only
  assign in_a0 = op_ior ? ~rs1_s0 : rs1_s0;
  assign in_b0 = op_ior ? ~rs2_s0 : rs2_s0;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready     = 1'b0;
    prng_upd  = 1'b0;
    case (state)
      IDLE: begin
        accept = valid & ~ready_q & (op_xor | op_and | op_ior | op_not);
        if (accept) state_nxt = (op_and | op_ior) ? CROSS : DONE;
      end
      CROSS:   state_nxt = GLITCH_REG ? RECOMB : DONE;
      RECOMB:  state_nxt = DONE;
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      ready     = 1'b0;
    end
    prng_upd = accept;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  // ISW recombination; cross terms are folded one at a time onto the
  // random mask so no cone ever sees both shares of one operand unmasked
  assign recomb    = GLITCH_REG ? u_q : (t_q ^ (a1_q & b0_q));
  assign and_s0    = (a0_q & b0_q) ^ m_q;
  assign and_s1    = (a1_q & b1_q) ^ recomb;
  assign write_and = GLITCH_REG ? (state == RECOMB) : (state == CROSS);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      ready_q <= 1'b0;
      ior_q   <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      m_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      rd_s0   <= '0;
      rd_s1   <= '0;
    end else if (flush) begin
      ready_q <= 1'b0;
      ior_q   <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      m_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      rd_s0   <= '0;
      rd_s1   <= '0;
    end else begin
      ready_q <= ready;
      if (accept) begin
        ior_q <= op_ior;
        a0_q  <= in_a0;
        a1_q  <= rs1_s1;
        b0_q  <= in_b0;
        b1_q  <= rs2_s1;
        m_q   <= prng;
        t_q   <= prng ^ (in_a0 & rs2_s1);
        if (op_xor) begin
          rd_s0 <= rs1_s0 ^ rs2_s0 ^ prng;
          rd_s1 <= rs1_s1 ^ rs2_s1 ^ prng;
        end else if (op_not) begin
          rd_s0 <= ~rs1_s0 ^ prng;
          rd_s1 <= rs1_s1 ^ prng;
        end
      end
      if (GLITCH_REG && state == CROSS) u_q <= t_q ^ (a1_q & b0_q);
      if (write_and) begin
        rd_s0 <= ior_q ? ~and_s0 : and_s0;
        rd_s1 <= and_s1;
      end
    end
  end

endmodule

// File: tb/tb_frv_masked_bitwise.sv
// tb_frv_masked_bitwise
//   Self-checking bench for frv_masked_bitwise: directed vectors plus random
//   AND/mixed vectors, with a behavioural model of the expected shares and
//   handshake timing checked every cycle.
module tb_frv_masked_bitwise;

  localparam int unsigned XLEN   = 32;
  localparam bit          GLITCH = 1'b1;
  localparam int OP_XOR = 0, OP_AND = 1, OP_IOR = 2, OP_NOT = 3;

  logic            g_clk = 1'b0;
  logic            g_resetn, flush, valid;
  logic            op_xor, op_and, op_ior, op_not;
  logic [XLEN-1:0] rs1_s0, rs1_s1, rs2_s0, rs2_s1, prng;
  logic            prng_upd, ready;
  logic [XLEN-1:0] rd_s0, rd_s1;

  frv_masked_bitwise #(.XLEN(XLEN), .GLITCH_REG(GLITCH)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .valid(valid),
    .op_xor(op_xor), .op_and(op_and), .op_ior(op_ior), .op_not(op_not),
    .rs1_s0(rs1_s0), .rs1_s1(rs1_s1), .rs2_s0(rs2_s0), .rs2_s1(rs2_s1),
    .prng(prng), .prng_upd(prng_upd), .ready(ready),
    .rd_s0(rd_s0), .rd_s1(rd_s1)
  );

  always #5 g_clk = ~g_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_ready_at = -1;
  int exp_upd_at   = -1;
  int n_ready = 0;
  int n_upd   = 0;
  logic [31:0] exp_s0 = '0, exp_s1 = '0;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Architectural result of each op on unmasked values
  function automatic logic [31:0] mdl_val(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_IOR:  return a | b;
      default: return ~a;
    endcase
  endfunction

  // Share 0 is fully determined by share-0 inputs and the mask
  function automatic logic [31:0] mdl_s0(input int op, input logic [31:0] a0, input logic [31:0] b0,
                                         input logic [31:0] m);
    case (op)
      OP_XOR:  return a0 ^ b0 ^ m;
      OP_AND:  return (a0 & b0) ^ m;
      OP_IOR:  return ~((~a0 & ~b0) ^ m);
      default: return ~a0 ^ m;
    endcase
  endfunction

  // Per-cycle compare against the model
  always @(negedge g_clk) begin
    chk("ready", {31'd0, ready}, {31'd0, cyc == exp_ready_at});
    chk("prng_upd", {31'd0, prng_upd}, {31'd0, cyc == exp_upd_at});
    if (ready) begin
      n_ready++;
      chk("rd_s0", rd_s0, exp_s0);
      chk("rd_s1", rd_s1, exp_s1);
    end
    if (prng_upd) n_upd++;
  end

  task automatic drive_op(input int op, input logic [31:0] a0, a1, b0, b1, m);
    op_xor = (op == OP_XOR);
    op_and = (op == OP_AND);
    op_ior = (op == OP_IOR);
    op_not = (op == OP_NOT);
    rs1_s0 = a0; rs1_s1 = a1; rs2_s0 = b0; rs2_s1 = b1;
    prng   = m;
    valid  = 1'b1;
    flush  = 1'b0;
    exp_upd_at   = cyc;
    exp_ready_at = cyc + ((op == OP_AND || op == OP_IOR) ? (GLITCH ? 3 : 2) : 1);
    exp_s0 = mdl_s0(op, a0, b0, m);
    exp_s1 = exp_s0 ^ mdl_val(op, a0 ^ a1, b0 ^ b1);
  endtask

  // Issue op, wait (bounded) for ready, keep valid held one more cycle
  task automatic do_op(input int op, input logic [31:0] a0, a1, b0, b1, m,
                       output logic [31:0] got0, output logic [31:0] got1);
    int lat;
    bit seen;
    @(posedge g_clk); #2;
    drive_op(op, a0, a1, b0, b1, m);
    lat  = exp_ready_at - cyc;
    seen = 1'b0;
    got0 = '0;
    got1 = '0;
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(posedge g_clk); #2;
      prng = $urandom;
      #1;
      if (ready) begin
        seen = 1'b1;
        got0 = rd_s0;
        got1 = rd_s1;
        chk("latency", k, lat);
      end
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge g_clk); #2;
    prng = $urandom;
  endtask

  task automatic go_idle();
    @(posedge g_clk); #2;
    valid = 1'b0;
    flush = 1'b0;
    op_xor = 1'b0; op_and = 1'b0; op_ior = 1'b0; op_not = 1'b0;
    prng = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] g0, g1, a, b, a0, b0;
    int r0, u0, op;
    g_resetn = 1'b0; flush = 1'b0; valid = 1'b0;
    op_xor = 1'b0; op_and = 1'b0; op_ior = 1'b0; op_not = 1'b0;
    rs1_s0 = '0; rs1_s1 = '0; rs2_s0 = '0; rs2_s1 = '0; prng = '0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_upd", {31'd0, prng_upd}, 32'd0);
    chk("rst_rd_s0", rd_s0, 32'd0);
    chk("rst_rd_s1", rd_s1, 32'd0);
    #1 g_resetn = 1'b1;

    // Model pins
    chk("model_xor", mdl_val(OP_XOR, 32'hDEADBEEF, 32'h0F0F0F0F), 32'hD1A2B1E0);
    chk("model_ior", mdl_val(OP_IOR, 32'h00000001, 32'h80000000), 32'h80000001);

    // Directed XOR plus handshake pulse counting
    r0 = n_ready; u0 = n_upd;
    do_op(OP_XOR, 32'hDEADBEEF ^ 32'h1234, 32'h1234, 32'h0F0F0F0F ^ 32'h55, 32'h55, 32'hA5A5A5A5, g0, g1);
    go_idle();
    chk("xor_unmasked", g0 ^ g1, 32'hD1A2B1E0);
    chk("xor_s0", g0, 32'hD1A2B1E0 ^ 32'h1261 ^ 32'hA5A5A5A5);
    chk("hs_ready_pulses", n_ready - r0, 32'd1);
    chk("hs_upd_pulses", n_upd - u0, 32'd1);

    // Directed AND
    do_op(OP_AND, 32'hFFFF0000 ^ 32'h3C3C5A5A, 32'h3C3C5A5A, 32'h0FF00FF0 ^ 32'h9E1B7C01, 32'h9E1B7C01,
          32'h6B2D0E77, g0, g1);
    chk("and_unmasked", g0 ^ g1, 32'h0FF00000);
    // IOR and NOT back-to-back with the AND
    do_op(OP_IOR, 32'h00000001 ^ 32'hC0FFEE00, 32'hC0FFEE00, 32'h80000000 ^ 32'h12345678, 32'h12345678,
          32'h0BADF00D, g0, g1);
    chk("ior_unmasked", g0 ^ g1, 32'h80000001);
    do_op(OP_NOT, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h77778888, g0, g1);
    chk("not_unmasked", g0 ^ g1, 32'hFFFFFFFF);
    go_idle();

    // Back-to-back: three ops, three ready pulses
    r0 = n_ready;
    do_op(OP_XOR, 32'h1, 32'h2, 32'h4, 32'h8, 32'hF0F0F0F0, g0, g1);
    do_op(OP_AND, 32'hFF, 32'h0F, 32'hF0, 32'h33, 32'h11111111, g0, g1);
    do_op(OP_NOT, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22222222, g0, g1);
    go_idle();
    chk("b2b_ready_pulses", n_ready - r0, 32'd3);

    // Flush in the CROSS cycle of an AND, then an XOR right after
    @(posedge g_clk); #2;
    drive_op(OP_AND, 32'hAAAA5555, 32'h12121212, 32'h0F0F0F0F, 32'h34343434, 32'h99999999);
    @(posedge g_clk); #2;
    flush = 1'b1;
    exp_ready_at = -1;
    #1 chk("flush_cross_ready", {31'd0, ready}, 32'd0);
    do_op(OP_XOR, 32'h11110000, 32'h0000FFFF, 32'h00FF00FF, 32'hF0F0F0F0, 32'h13572468, g0, g1);
    chk("after_flush_xor", g0 ^ g1, 32'h11110000 ^ 32'h0000FFFF ^ 32'h00FF00FF ^ 32'hF0F0F0F0);
    go_idle();

    // Flush in the DONE cycle suppresses ready
    @(posedge g_clk); #2;
    drive_op(OP_XOR, 32'h1, 32'h0, 32'h2, 32'h0, 32'h3);
    @(posedge g_clk); #2;
    flush = 1'b1;
    exp_ready_at = -1;
    #1 chk("flush_done_ready", {31'd0, ready}, 32'd0);
    go_idle();

    // Flush with valid in IDLE drops the request
    @(posedge g_clk); #2;
    drive_op(OP_XOR, 32'h5, 32'h0, 32'h6, 32'h0, 32'h7);
    flush = 1'b1;
    exp_upd_at = -1;
    exp_ready_at = -1;
    #1 chk("flush_idle_upd", {31'd0, prng_upd}, 32'd0);
    go_idle();
    go_idle();

    // Reset mid-AND
    do_op(OP_XOR, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, g0, g1);
    go_idle();
    @(posedge g_clk); #2;
    drive_op(OP_AND, 32'hFFFF0000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
    @(posedge g_clk); #2;
    g_resetn = 1'b0;
    valid = 1'b0;
    exp_ready_at = -1;
    #1;
    chk("rst_mid_ready", {31'd0, ready}, 32'd0);
    chk("rst_mid_rd_s0", rd_s0, 32'd0);
    chk("rst_mid_rd_s1", rd_s1, 32'd0);
    @(posedge g_clk); #2;
    @(posedge g_clk); #2;
    g_resetn = 1'b1;
    do_op(OP_XOR, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0, 32'h0, g0, g1);
    chk("after_rst_xor", g0 ^ g1, 32'hCAFEBABE);
    go_idle();

    // 1000 random AND vectors
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; a0 = $urandom; b0 = $urandom;
      do_op(OP_AND, a0, a0 ^ a, b0, b0 ^ b, $urandom, g0, g1);
      if (i % 100 == 0) chk("rand_and", g0 ^ g1, a & b);
      go_idle();
    end

    // Mixed random ops, back-to-back
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(3, 0));
      a = $urandom; b = $urandom; a0 = $urandom; b0 = $urandom;
      do_op(op, a0, a0 ^ a, b0, b0 ^ b, $urandom, g0, g1);
    end
    go_idle();
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
